display_source_scheduler: RTL
=============================

Name: display_source_scheduler

Overview:
Shares the single 8-digit seven-segment display between up to NUM_SRC 32-bit data sources, such as PC, instruction, cycle count and syscall output. Each source's latest value is buffered in a shadow register. The block picks which buffer drives the Display data input, using one of three selection methods:
- auto-rotation on a dwell timer;
- manual stepping with a debounced button;
- priority pinning, for example when a syscall display request arrives.

It sits between the CPU datapath and the Display scan driver, and feeds its data port.

Parameters:
NUM_SRC, 4, number of display sources (2..8)
SEL_W, 2, width of the source index, equal to ceil(log2(NUM_SRC))
DWELL, 50_000_000, clock cycles each source is shown in auto mode (at least 2)
DEBOUNCE, 1_000_000, cycles next_btn must be stable before a change is accepted (at least 2)

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-low reset
src_data  input  NUM_SRC*32  source i occupies bits [32*i+31:32*i]
src_load  input  NUM_SRC  per-source capture strobe
src_enable  input  NUM_SRC  source takes part in rotation and manual stepping
auto_mode  input  1  1 = auto-rotate, 0 = manual step
next_btn  input  1  raw, asynchronous push-button
pin_req  input  NUM_SRC  level pin request per source
disp_data  output  32  word sent to Display.data
disp_sel  output  SEL_W  index currently displayed
disp_blank  output  1  no source selectable; Display should be blanked
pin_ack  output  NUM_SRC  one-hot; the currently pinned source

Behaviour:
- Reset (reset=0, asynchronous):
  - shadows = 0, disp_data = 0, disp_sel = 0, disp_blank = 1, pin_ack = 0.
  - state = IDLE; dwell counter, debounce counter and synchronisers cleared; saved_sel = 0.
  - Reset asserted mid-operation aborts everything immediately, including any pin.
- Shadow buffering:
  - src_load[i] high at edge k: shadow[i] takes the new value at k.
  - disp_data reflects shadow[disp_sel] at k+1, a fixed one-register latency.
  - Loads to non-displayed sources are buffered silently.
- Next-enabled search: starting from cur+1, wrap modulo NUM_SRC, take the first index with src_enable set. If cur is the only enabled source, the result is cur.
- State machine:
  - IDLE:
    - disp_blank = 1.
    - If any pin_req is high, go to PINNED. Otherwise, if any src_enable is high, go to SHOW with disp_sel = lowest enabled index.
  - SHOW:
    - disp_blank = 0.
    - If all src_enable are 0, go to IDLE, keeping disp_sel.
    - If the current disp_sel loses its enable, advance to next-enabled on the following edge.
    - Auto mode: the dwell counter runs 0..DWELL-1. On the terminal count, advance to next-enabled. The counter clears to 0 on every disp_sel change and whenever auto_mode is 0.
    - Manual mode:
      - next_btn passes through a 2-flop synchroniser.
      - A debounced level changes only after the synchronised input has differed from it for DEBOUNCE consecutive cycles.
      - Each 0→1 transition of the debounced level advances exactly once.
      - A button press while auto_mode=1 is ignored.
    - Any pin_req high: set saved_sel = disp_sel and go to PINNED.
  - PINNED:
    - disp_sel = lowest index with pin_req high, regardless of src_enable; pin_ack = one-hot of that index; disp_blank = 0.
    - A lower-index pin_req rising preempts the current pin on the next edge.
    - A higher-index request waits.
    - When all pin_req are low: pin_ack = 0, then return to SHOW with disp_sel = saved_sel and the dwell counter cleared. Enable rules are re-applied on the next cycle.
    - If PINNED was entered from IDLE, return to IDLE.
- Simultaneous events:
  - Priority order: pin > disable-of-current > dwell terminal / button advance.
  - A dwell terminal and a button edge in the same cycle cause a single advance.
  - src_load and a disp_sel change on the same edge: disp_data shows the new source's shadow one cycle later, including that same-edge load.
- All outputs are registered.

Test Plan:
1. Reset values: with DWELL=4, release reset with src_enable=0000 → disp_blank=1, disp_sel=0, disp_data=0, pin_ack=0; these hold for 10 cycles.
2. Load latency:
   - src_enable=0001; load src0 = 32'h12345678 at edge k → disp_data = 32'h12345678 at k+1.
   - Load src2 = 32'hDEADBEEF → disp_data unchanged.
3. Auto rotation with wrap, DWELL=4, src_enable=1011, auto_mode=1 → disp_sel sequence 0,1,3,0, each held exactly 4 cycles.
   - Clear enable[1] while disp_sel=1 → disp_sel=3 on the next edge, and the counter restarts.
4. Manual debounce, DEBOUNCE=3, auto_mode=0, src_enable=1111:
   - 2-cycle glitch on next_btn → no change.
   - Clean press held 6 cycles → disp_sel advances 0→1 exactly once.
   - Press and release four times → disp_sel wraps back to 1.
5. Pinning and preemption:
   - In SHOW with disp_sel=1, raise pin_req[3] → disp_sel=3, pin_ack=1000.
   - Raise pin_req[2] → disp_sel=2, pin_ack=0100.
   - Drop both → disp_sel=1, pin_ack=0000, dwell counter restarts at 0.
6. Asynchronous reset while PINNED → all outputs return to their reset values immediately, without waiting for a clock edge; state is IDLE after release.

Source files
------------

// File: rtl/display_source_scheduler.sv
// Shares one 8-digit seven-segment display between NUM_SRC buffered 32-bit sources.
// Selection is by auto-rotation, debounced manual stepping, or priority pinning.
module display_source_scheduler #(
    parameter int NUM_SRC  = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 50_000_000,
    parameter int DEBOUNCE = 1_000_000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_SRC*32-1:0]   src_data,
    input  logic [NUM_SRC-1:0]      src_load,
    input  logic [NUM_SRC-1:0]      src_enable,
    input  logic                    auto_mode,
    input  logic                    next_btn,
    input  logic [NUM_SRC-1:0]      pin_req,
    output logic [31:0]             disp_data,
    output logic [SEL_W-1:0]        disp_sel,
    output logic                    disp_blank,
    output logic [NUM_SRC-1:0]      pin_ack
);

    localparam int DW_W = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam int DB_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_PINNED = 2'd2
    } state_t;

    function automatic logic [SEL_W-1:0] f_lowest(input logic [NUM_SRC-1:0] vec);
        logic [SEL_W-1:0] res;
        res = {SEL_W{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res = SEL_W'(i);
            end
        end
        return res;
    endfunction

    // First enabled index after cur, wrapping; cur itself if nothing else is enabled.
    function automatic logic [SEL_W-1:0] f_next_en(input logic [SEL_W-1:0] cur,
                                                   input logic [NUM_SRC-1:0] en);
        logic [SEL_W-1:0] hi_idx;
        logic [SEL_W-1:0] lo_idx;
        logic             hi_found;
        logic             lo_found;
        hi_idx   = {SEL_W{1'b0}};
        lo_idx   = {SEL_W{1'b0}};
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (en[i] && (i > int'(cur))) begin
                hi_idx   = SEL_W'(i);
                hi_found = 1'b1;
            end else if (en[i]) begin
                lo_idx   = SEL_W'(i);
                lo_found = 1'b1;
            end
        end
        if (hi_found) begin
            return hi_idx;
        end else if (lo_found) begin
            return lo_idx;
        end else begin
            return cur;
        end
    endfunction

    function automatic logic [NUM_SRC-1:0] f_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_SRC-1:0] oh;
        oh = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            oh[i] = (SEL_W'(i) == idx);
        end
        return oh;
    endfunction

    logic [31:0]        r_shadow [NUM_SRC];
    logic [31:0]        r_disp_data;
    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_saved_sel;
    logic               r_from_idle;
    logic [DW_W-1:0]    r_dwell;
    logic               r_blank;
    logic [NUM_SRC-1:0] r_pin_ack;
    logic [1:0]         r_sync;
    logic               r_btn_db;
    logic [DB_W-1:0]    r_db_cnt;

    state_t             w_state_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [SEL_W-1:0]   w_saved_nxt;
    logic               w_from_idle_nxt;
    logic [DW_W-1:0]    w_dwell_nxt;
    logic               w_blank_nxt;
    logic [NUM_SRC-1:0] w_ack_nxt;
    logic               w_btn_rise;
    logic               w_advance;
    logic               w_pin_any;
    logic [SEL_W-1:0]   w_pin_idx;

    // Shadow buffers and the display word, one register behind the selected shadow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_shadow[i] <= 32'h0000_0000;
            end
            r_disp_data <= 32'h0000_0000;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_load[i]) begin
                    r_shadow[i] <= src_data[32*i +: 32];
                end
            end
            r_disp_data <= r_shadow[r_sel];
        end
    end

    // Button synchroniser and debouncer; level flips after DEBOUNCE differing cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync   <= 2'b00;
            r_btn_db <= 1'b0;
            r_db_cnt <= {DB_W{1'b0}};
        end else begin
            r_sync <= {r_sync[0], next_btn};
            if (r_sync[1] != r_btn_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_btn_db <= r_sync[1];
                    r_db_cnt <= {DB_W{1'b0}};
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end else begin
                r_db_cnt <= {DB_W{1'b0}};
            end
        end
    end

    assign w_btn_rise = r_sync[1] && !r_btn_db && (r_db_cnt == DB_LAST);
    assign w_advance  = (auto_mode && (r_dwell == DW_LAST)) || (!auto_mode && w_btn_rise);
    assign w_pin_any  = |pin_req;
    assign w_pin_idx  = f_lowest(pin_req);

    // Next state and next registered outputs; pin outranks disable, which outranks advance.
    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_saved_nxt     = r_saved_sel;
        w_from_idle_nxt = r_from_idle;
        w_dwell_nxt     = {DW_W{1'b0}};
        w_blank_nxt     = r_blank;
        w_ack_nxt       = {NUM_SRC{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (w_pin_any) begin
                    w_state_nxt     = ST_PINNED;
                    w_sel_nxt       = w_pin_idx;
                    w_ack_nxt       = f_onehot(w_pin_idx);
                    w_blank_nxt     = 1'b0;
                    w_from_idle_nxt = 1'b1;
                end else if (|src_enable) begin
                    w_state_nxt = ST_SHOW;
                    w_sel_nxt   = f_lowest(src_enable);
                    w_blank_nxt = 1'b0;
                end else begin
                    w_blank_nxt = 1'b1;
                end
            end
            ST_SHOW: begin
                w_blank_nxt = 1'b0;
                if (w_pin_any) begin
                    w_state_nxt     = ST_PINNED;
                    w_saved_nxt     = r_sel;
                    w_from_idle_nxt = 1'b0;
                    w_sel_nxt       = w_pin_idx;
                    w_ack_nxt       = f_onehot(w_pin_idx);
                end else if (!(|src_enable)) begin
                    w_state_nxt = ST_IDLE;
                    w_blank_nxt = 1'b1;
                end else if (!src_enable[r_sel] || w_advance) begin
                    w_sel_nxt = f_next_en(r_sel, src_enable);
                end else if (auto_mode) begin
                    w_dwell_nxt = r_dwell + DW_W'(1);
                end else begin
                    w_dwell_nxt = {DW_W{1'b0}};
                end
            end
            ST_PINNED: begin
                if (w_pin_any) begin
                    w_sel_nxt   = w_pin_idx;
                    w_ack_nxt   = f_onehot(w_pin_idx);
                    w_blank_nxt = 1'b0;
                end else if (r_from_idle) begin
                    w_state_nxt     = ST_IDLE;
                    w_from_idle_nxt = 1'b0;
                    w_blank_nxt     = 1'b1;
                end else begin
                    w_state_nxt = ST_SHOW;
                    w_sel_nxt   = r_saved_sel;
                    w_blank_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_blank_nxt = 1'b1;
            end
        endcase
    end

    // Scheduler state and registered display controls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_sel       <= {SEL_W{1'b0}};
            r_saved_sel <= {SEL_W{1'b0}};
            r_from_idle <= 1'b0;
            r_dwell     <= {DW_W{1'b0}};
            r_blank     <= 1'b1;
            r_pin_ack   <= {NUM_SRC{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_saved_sel <= w_saved_nxt;
            r_from_idle <= w_from_idle_nxt;
            r_dwell     <= w_dwell_nxt;
            r_blank     <= w_blank_nxt;
            r_pin_ack   <= w_ack_nxt;
        end
    end

    assign disp_data  = r_disp_data;
    assign disp_sel   = r_sel;
    assign disp_blank = r_blank;
    assign pin_ack    = r_pin_ack;

endmodule
